// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types for the fetch stage and its stage registers.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus_4;
    logic            valid;
  } if_id_t;

  // Sequential successor of a fetch address, wrapping at 2^32.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline stage register: stall holds, flush or no-load inserts a bubble.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall,
  input  logic   flush,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  // A bubble keeps the previous pc_plus_4 so only instr/valid change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.instr     <= NOP;
      q.pc_plus_4 <= '0;
      q.valid     <= 1'b0;
    end else if (!stall) begin
      if (flush || !load) begin
        q.instr <= NOP;
        q.valid <= 1'b0;
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake, IF/ID register.
// Optional misaligned-redirect detection enabled by FETCH_ALIGN_CHECK_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_f_i,
  input  logic        stall_d_i,
  input  logic        flush_d_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_d_o,
  output logic [31:0] pc_plus_4_d_o,
  output logic        valid_d_o,
  output logic        misaligned_o
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc_f, pc_f_nxt;
  logic [31:0]  hold_word, hold_word_nxt;
  logic         halt, halt_nxt;
  logic [31:0]  target;
  logic         target_bad;
  logic         req;
  logic         deliver;
  logic [31:0]  deliver_word;
  if_id_t       if_id_d, if_id_q;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target     = redirect_pc_i;
  assign target_bad = |redirect_pc_i[1:0];
`else
  assign target     = redirect_pc_i & 32'hffff_fffc;
  assign target_bad = 1'b0;
`endif

  // Next-state, PC and buffer update; redirect overrides everything last.
  always_comb begin
    state_nxt     = state;
    pc_f_nxt      = pc_f;
    hold_word_nxt = hold_word;
    halt_nxt      = halt;
    req           = 1'b0;
    deliver       = 1'b0;
    deliver_word  = hold_word;
    case (state)
      FETCH: begin
        if (!redirect_i && !stall_f_i && !halt) begin
          req       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (redirect_i) begin
            state_nxt = FETCH;
          end else if (!stall_d_i) begin
            deliver      = 1'b1;
            deliver_word = imem_rdata_i;
            pc_f_nxt     = pc_inc(pc_f);
            state_nxt    = FETCH;
          end else begin
            hold_word_nxt = imem_rdata_i;
            state_nxt     = FULL;
          end
        end else if (redirect_i) begin
          state_nxt = DROP;
        end
      end
      FULL: begin
        if (redirect_i) begin
          state_nxt = FETCH;
        end else if (!stall_d_i) begin
          deliver   = 1'b1;
          pc_f_nxt  = pc_inc(pc_f);
          state_nxt = FETCH;
        end
      end
      DROP: begin
        if (imem_rvalid_i) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    if (redirect_i) begin
      pc_f_nxt      = target;
      hold_word_nxt = NOP;
      halt_nxt      = halt | target_bad;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= FETCH;
      pc_f      <= RESET_PC;
      hold_word <= NOP;
      halt      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc_f      <= pc_f_nxt;
      hold_word <= hold_word_nxt;
      halt      <= halt_nxt;
    end
  end

  // Request is a same-cycle pulse so a 1-cycle memory sustains one word per 2 cycles.
  assign imem_req_o  = req & rst_ni;
  assign imem_addr_o = pc_f;

  assign if_id_d.instr     = deliver_word;
  assign if_id_d.pc_plus_4 = pc_inc(pc_f);
  assign if_id_d.valid     = 1'b1;

  if_id_reg #(.NOP(NOP)) u_if_id (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .stall (stall_d_i),
    .flush (flush_d_i),
    .load  (deliver),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign instr_d_o     = if_id_q.instr;
  assign pc_plus_4_d_o = if_id_q.pc_plus_4;
  assign valid_d_o     = if_id_q.valid;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned_o = halt;
`else
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        stall_f_i = 1'b0, stall_d_i = 1'b0, flush_d_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] instr_d_o, pc_plus_4_d_o;
  logic        valid_d_o, misaligned_o;

  always #5 clk_i = ~clk_i;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP(NOP)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .stall_f_i(stall_f_i), .stall_d_i(stall_d_i), .flush_d_i(flush_d_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_d_o(instr_d_o), .pc_plus_4_d_o(pc_plus_4_d_o), .valid_d_o(valid_d_o),
    .misaligned_o(misaligned_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
  endfunction

  // Memory environment: one outstanding request, fixed latency, optional junk rvalids.
  int          lat = 1;
  bit          mem_busy;
  int          mem_left;
  logic [31:0] mem_addr;
  bit          spurious_en;

  // Reference model: what is in flight, what is buffered, where program order continues.
  bit          m_out, m_stale, m_hold, m_halt;
  logic [31:0] m_out_addr, m_hold_word, m_hold_addr, m_pc;
  logic [31:0] e_instr, e_p4;
  bit          e_valid;

  int          cyc;
  int          req_cyc[$];
  logic [31:0] req_addr[$];
  int          val_cyc[$];
  logic [31:0] val_instr[$];

  task automatic model_reset();
    m_out = 0; m_stale = 0; m_hold = 0; m_halt = 0;
    m_out_addr = '0; m_hold_word = '0; m_hold_addr = '0; m_pc = RESET_PC;
    e_instr = NOP; e_p4 = '0; e_valid = 0;
    mem_busy = 0; mem_left = 0; mem_addr = '0;
    cyc = 0;
    req_cyc.delete(); req_addr.delete(); val_cyc.delete(); val_instr.delete();
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    stall_f_i = 0; stall_d_i = 0; flush_d_i = 0; redirect_i = 0; redirect_pc_i = '0;
    imem_rvalid_i = 0; imem_rdata_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_req",   32'(imem_req_o), 32'd0);
    check_eq("rst_addr",  imem_addr_o, RESET_PC);
    check_eq("rst_instr", instr_d_o, NOP);
    check_eq("rst_p4",    pc_plus_4_d_o, 32'd0);
    check_eq("rst_valid", 32'(valid_d_o), 32'd0);
    check_eq("rst_mis",   32'(misaligned_o), 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic cycle(input bit sf, input bit sd, input bit fl, input bit rd, input logic [31:0] tgt);
    logic [31:0] t, rdat, dw, da, pc_now;
    bit bad, rv, req_exp, fin, deliver;
    stall_f_i = sf; stall_d_i = sd; flush_d_i = fl; redirect_i = rd; redirect_pc_i = tgt;
    rv = 0;
    rdat = $urandom;
    if (mem_busy) begin
      mem_left--;
      if (mem_left == 0) begin
        rv = 1; rdat = mem_word(mem_addr); mem_busy = 0;
      end
    end else if (spurious_en && $urandom_range(0, 9) == 0) begin
      rv = 1;
    end
    imem_rvalid_i = rv; imem_rdata_i = rdat;
    @(negedge clk_i);
`ifdef FETCH_ALIGN_CHECK_EN
    t = tgt; bad = (tgt[1:0] != 2'b00);
`else
    t = {tgt[31:2], 2'b00}; bad = 0;
`endif
    pc_now  = m_pc;
    req_exp = !m_out && !m_hold && !sf && !rd && !m_halt;
    check_eq("req", 32'(imem_req_o), 32'(req_exp));
    if (req_exp && imem_req_o) check_eq("addr", imem_addr_o, pc_now);
    check_eq("instr", instr_d_o, e_instr);
    check_eq("p4",    pc_plus_4_d_o, e_p4);
    check_eq("valid", 32'(valid_d_o), 32'(e_valid));
    check_eq("mis",   32'(misaligned_o), 32'(m_halt));
    if (imem_req_o) begin req_cyc.push_back(cyc); req_addr.push_back(imem_addr_o); end
    if (valid_d_o) begin val_cyc.push_back(cyc); val_instr.push_back(instr_d_o); end
    // Advance the model by one clock edge.
    deliver = 0; dw = NOP; da = '0;
    fin = m_out && rv;
    if (fin && !m_stale && !rd) begin
      if (!sd) begin deliver = 1; dw = rdat; da = m_out_addr; end
      else begin m_hold = 1; m_hold_word = rdat; m_hold_addr = m_out_addr; end
    end else if (m_hold && !rd && !sd) begin
      deliver = 1; dw = m_hold_word; da = m_hold_addr; m_hold = 0;
    end
    if (rd) begin
      m_hold = 0; m_pc = t;
      if (bad) m_halt = 1;
      if (m_out && !rv) m_stale = 1;
    end else if (deliver) begin
      m_pc = da + 32'd4;
    end
    if (fin) m_out = 0;
    if (req_exp) begin m_out = 1; m_stale = 0; m_out_addr = pc_now; end
    if (!sd) begin
      if (fl || !deliver) begin e_instr = NOP; e_valid = 0; end
      else begin e_instr = dw; e_p4 = da + 32'd4; e_valid = 1; end
    end
    if (imem_req_o) begin mem_busy = 1; mem_left = lat; mem_addr = imem_addr_o; end
    @(posedge clk_i);
    #1 cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, '0);
  endtask

  initial begin
    spurious_en = 0;

    // Back-to-back fetch with 1-cycle memory.
    lat = 1; apply_reset(); idle(7);
    check_eq("d1_nreq", 32'(req_addr.size() >= 3), 32'd1);
    if (req_addr.size() >= 3 && val_cyc.size() >= 1) begin
      check_eq("d1_a0", req_addr[0], 32'h0);
      check_eq("d1_a1", req_addr[1], 32'h4);
      check_eq("d1_a2", req_addr[2], 32'h8);
      check_eq("d1_c0", 32'(req_cyc[0]), 32'd0);
      check_eq("d1_gap", 32'(req_cyc[1] - req_cyc[0]), 32'd2);
      check_eq("d1_lat", 32'(val_cyc[0] - req_cyc[0]), 32'd2);
    end

    // 3-cycle memory: one instruction every 4 cycles.
    lat = 3; apply_reset(); idle(14);
    check_eq("d2_nval", 32'(val_cyc.size() >= 3), 32'd1);
    if (val_cyc.size() >= 3) begin
      check_eq("d2_gap0", 32'(val_cyc[1] - val_cyc[0]), 32'd4);
      check_eq("d2_gap1", 32'(val_cyc[2] - val_cyc[1]), 32'd4);
    end

    // Decode stalled across the response: word parked, released after stall drops.
    lat = 1; apply_reset();
    cycle(0, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, '0);
    idle(2);
    check_eq("d3_nreq", 32'(req_cyc.size()), 32'd2);
    check_eq("d3_nval", 32'(val_cyc.size()), 32'd1);
    if (val_cyc.size() >= 1 && req_cyc.size() >= 2) begin
      check_eq("d3_vcyc", 32'(val_cyc[0]), 32'd5);
      check_eq("d3_word", val_instr[0], mem_word(32'h0));
      check_eq("d3_rcyc", 32'(req_cyc[1]), 32'd5);
    end

    // Redirect while waiting: stale response dropped, refetch at target.
    lat = 3; apply_reset();
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 1, 32'h0000_0100);
    idle(4);
    check_eq("d4_nval", 32'(val_cyc.size()), 32'd0);
    if (req_addr.size() >= 2) begin
      check_eq("d4_addr", req_addr[1], 32'h0000_0100);
      check_eq("d4_rcyc", 32'(req_cyc[1]), 32'd4);
    end else check_eq("d4_nreq", 32'(req_addr.size()), 32'd2);

    // Redirect coinciding with rvalid: word discarded, immediate refetch.
    lat = 1; apply_reset();
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 1, 32'h0000_0200);
    idle(2);
    check_eq("d5_nval", 32'(val_cyc.size()), 32'd0);
    if (req_addr.size() >= 2) begin
      check_eq("d5_addr", req_addr[1], 32'h0000_0200);
      check_eq("d5_rcyc", 32'(req_cyc[1]), 32'd2);
    end else check_eq("d5_nreq", 32'(req_addr.size()), 32'd2);

    // Wrap-around of pc_plus_4 at the top of the address space.
    lat = 1; apply_reset();
    cycle(0, 0, 0, 1, 32'hffff_fffc);
    idle(4);
    check_eq("d6_wrap_a", (req_addr.size() >= 1) ? req_addr[0] : 32'hdead_beef, 32'hffff_fffc);

    // Misaligned redirect target.
    lat = 1; apply_reset();
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 1, 32'h0000_0102);
    idle(4);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq("d7_mis",  32'(misaligned_o), 32'd1);
    check_eq("d7_nreq", 32'(req_cyc.size()), 32'd1);
`else
    check_eq("d7_mis", 32'(misaligned_o), 32'd0);
    check_eq("d7_addr", (req_addr.size() >= 2) ? req_addr[1] : 32'hdead_beef, 32'h0000_0100);
`endif

    // Randomized traffic; each segment starts with a reset that may land mid-transaction.
    spurious_en = 1;
    for (int seg = 0; seg < 6; seg++) begin
      lat = $urandom_range(1, 4);
      apply_reset();
      for (int i = 0; i < 300; i++) begin
        logic [31:0] tgt;
        bit sf, sd, fl, rd;
        sf = ($urandom_range(0, 99) < 15);
        sd = ($urandom_range(0, 99) < 20);
        fl = ($urandom_range(0, 99) < 10);
        rd = ($urandom_range(0, 99) < 7);
        tgt = {16'h0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))} & 32'h0000_fffc;
        if ($urandom_range(0, 9) == 0) tgt = 32'hffff_fff8;
`ifndef FETCH_ALIGN_CHECK_EN
        tgt[1:0] = 2'($urandom_range(0, 3));
`endif
        cycle(sf, sd, fl, rd, tgt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
